// File: rtl/vga_text_scheduler.sv
// Character/row/column scheduler that turns a text-draw request into one pixel plot per cycle.
// Per character: 2 fetch cycles + CHAR_H*(2 + CHAR_W); new requests are accepted only in IDLE.
module vga_text_scheduler #(
   parameter int COL_W    = 3,
   parameter int ROW_W    = 3,
   parameter int X_W      = 8,
   parameter int Y_W      = 7,
   parameter int SCREEN_W = 160,
   parameter int SCREEN_H = 120,
   parameter int ADDR_W   = 8,
   parameter int LEN_W    = 6,
   parameter int CODE_W   = 7
) (
   input  logic                      clock,
   input  logic                      resetn,
   input  logic                      req,
   output logic                      req_ready,
   input  logic [X_W-1:0]            req_x,
   input  logic [Y_W-1:0]            req_y,
   input  logic [LEN_W-1:0]          req_len,
   input  logic [ADDR_W-1:0]         req_addr,
   input  logic [2:0]                fg_colour,
   input  logic [2:0]                bg_colour,
   output logic [ADDR_W-1:0]         mem_addr,
   input  logic [CODE_W-1:0]         mem_data,
   output logic [CODE_W+ROW_W-1:0]   font_addr,
   input  logic [(1<<COL_W)-1:0]     font_row,
   output logic                      plot,
   output logic [X_W-1:0]            vga_x,
   output logic [Y_W-1:0]            vga_y,
   output logic [2:0]                colour,
   output logic                      busy,
   output logic                      done
);
   localparam int CHAR_W = 1 << COL_W;
   localparam int CHAR_H = 1 << ROW_W;
   localparam int XF_W   = X_W + LEN_W + COL_W;
   localparam int YF_W   = Y_W + 1;

   typedef enum logic [2:0] {
      IDLE, FETCH_CHAR, WAIT_CHAR, FETCH_ROW, WAIT_ROW, DRAW, DONE
   } state_t;

   state_t              state;
   logic [Y_W-1:0]      base_y;
   logic [LEN_W-1:0]    len;
   logic [ADDR_W-1:0]   addr;
   logic [2:0]          fg;
   logic [2:0]          bg;
   logic [LEN_W-1:0]    idx;
   logic [ROW_W-1:0]    row;
   logic [COL_W-1:0]    col;
   logic [CODE_W-1:0]   code;
   logic [CHAR_W-1:0]   shreg;
   logic [XF_W-1:0]     char_x;

   logic [COL_W-1:0]    pix_col;
   logic [XF_W-1:0]     pix_x;
   logic [YF_W-1:0]     pix_y;
   logic                pix_on;
   logic                pix_bit;

   assign req_ready = (state == IDLE);
   assign busy      = (state != IDLE);

   // Coordinates of the pixel being registered this cycle: column 0 when leaving
   // WAIT_ROW, otherwise the column after the one currently on the outputs.
   always_comb begin
      pix_col = '0;
      pix_bit = font_row[CHAR_W-1];
      if (state == DRAW) begin
         pix_col = col + COL_W'(1);
         pix_bit = shreg[CHAR_W-1];
      end
      pix_x  = char_x + XF_W'(pix_col);
      pix_y  = YF_W'(base_y) + YF_W'(row);
      pix_on = (pix_x < XF_W'(SCREEN_W)) && (pix_y < YF_W'(SCREEN_H));
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state     <= IDLE;
         base_y    <= '0;
         len       <= '0;
         addr      <= '0;
         fg        <= '0;
         bg        <= '0;
         idx       <= '0;
         row       <= '0;
         col       <= '0;
         code      <= '0;
         shreg     <= '0;
         char_x    <= '0;
         mem_addr  <= '0;
         font_addr <= '0;
         plot      <= 1'b0;
         vga_x     <= '0;
         vga_y     <= '0;
         colour    <= '0;
         done      <= 1'b0;
      end else begin
         plot <= 1'b0;
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (req) begin
                  base_y <= req_y;
                  len    <= req_len;
                  addr   <= req_addr;
                  fg     <= fg_colour;
                  bg     <= bg_colour;
                  idx    <= '0;
                  row    <= '0;
                  col    <= '0;
                  char_x <= XF_W'(req_x);
                  if (req_len == '0) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     mem_addr <= req_addr;
                     state    <= FETCH_CHAR;
                  end
               end
            end
            FETCH_CHAR: state <= WAIT_CHAR;
            WAIT_CHAR: begin
               code      <= mem_data;
               font_addr <= {mem_data, row};
               state     <= FETCH_ROW;
            end
            FETCH_ROW: state <= WAIT_ROW;
            WAIT_ROW: begin
               shreg  <= font_row << 1;
               col    <= '0;
               plot   <= pix_on;
               vga_x  <= pix_x[X_W-1:0];
               vga_y  <= pix_y[Y_W-1:0];
               colour <= pix_bit ? fg : bg;
               state  <= DRAW;
            end
            DRAW: begin
               if (col != COL_W'(CHAR_W - 1)) begin
                  col    <= col + COL_W'(1);
                  shreg  <= shreg << 1;
                  plot   <= pix_on;
                  vga_x  <= pix_x[X_W-1:0];
                  vga_y  <= pix_y[Y_W-1:0];
                  colour <= pix_bit ? fg : bg;
               end else begin
                  col <= '0;
                  if (row != ROW_W'(CHAR_H - 1)) begin
                     row       <= row + ROW_W'(1);
                     font_addr <= {code, row + ROW_W'(1)};
                     state     <= FETCH_ROW;
                  end else if (idx != len - LEN_W'(1)) begin
                     idx      <= idx + LEN_W'(1);
                     row      <= '0;
                     char_x   <= char_x + XF_W'(CHAR_W);
                     mem_addr <= addr + ADDR_W'(idx) + ADDR_W'(1);
                     state    <= FETCH_CHAR;
                  end else begin
                     done  <= 1'b1;
                     state <= DONE;
                  end
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_vga_text_scheduler.sv
// Bench for vga_text_scheduler: vector table plus scoreboard of expected pixels.
module tb_vga_text_scheduler;
   logic       clock = 1'b0;
   logic       resetn;
   logic       req;
   logic       req_ready;
   logic [7:0] req_x;
   logic [6:0] req_y;
   logic [5:0] req_len;
   logic [7:0] req_addr;
   logic [2:0] fg_colour, bg_colour;
   logic [7:0] mem_addr;
   logic [6:0] mem_data;
   logic [9:0] font_addr;
   logic [7:0] font_row;
   logic       plot;
   logic [7:0] vga_x;
   logic [6:0] vga_y;
   logic [2:0] colour;
   logic       busy, done;

   vga_text_scheduler dut (
      .clock(clock), .resetn(resetn), .req(req), .req_ready(req_ready),
      .req_x(req_x), .req_y(req_y), .req_len(req_len), .req_addr(req_addr),
      .fg_colour(fg_colour), .bg_colour(bg_colour),
      .mem_addr(mem_addr), .mem_data(mem_data),
      .font_addr(font_addr), .font_row(font_row),
      .plot(plot), .vga_x(vga_x), .vga_y(vga_y), .colour(colour),
      .busy(busy), .done(done)
   );

   always #5 clock = ~clock;

   logic [6:0] tmem [0:255];
   logic [7:0] font [0:1023];

   always @(posedge clock) begin
      mem_data <= tmem[mem_addr];
      font_row <= font[font_addr];
   end

   typedef struct {
      logic [7:0] x;
      logic [6:0] y;
      logic [5:0] len;
      logic [7:0] addr;
      logic [2:0] fg;
      logic [2:0] bg;
      int         poke;
      int         exp_busy;
      int         exp_plots;
   } vec_t;

   typedef struct { int x; int y; int c; } pix_t;

   pix_t exp_q [$];
   int checks = 0;
   int errors = 0;
   int busy_cnt, plot_cnt, done_cnt, done_at, ready_viol;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   always @(negedge clock) begin
      if (resetn) begin
         if (busy) busy_cnt++;
         if (busy && req_ready) ready_viol++;
         if (done) begin
            done_cnt++;
            done_at = busy_cnt;
         end
         if (plot) begin
            plot_cnt++;
            if (exp_q.size() == 0) begin
               chk("unexpected_plot", 1, 0);
            end else begin
               pix_t e;
               e = exp_q.pop_front();
               chk("pix_x", int'(vga_x), e.x);
               chk("pix_y", int'(vga_y), e.y);
               chk("pix_colour", int'(colour), e.c);
            end
         end
      end
   end

   task automatic push_model(input vec_t v);
      for (int i = 0; i < int'(v.len); i++) begin
         logic [7:0] a;
         logic [6:0] code;
         a    = 8'(int'(v.addr) + i);
         code = tmem[a];
         for (int r = 0; r < 8; r++) begin
            logic [7:0] bits;
            bits = font[int'(code) * 8 + r];
            for (int c = 0; c < 8; c++) begin
               pix_t p;
               p.x = int'(v.x) + i * 8 + c;
               p.y = int'(v.y) + r;
               p.c = bits[7 - c] ? int'(v.fg) : int'(v.bg);
               if (p.x < 160 && p.y < 120) exp_q.push_back(p);
            end
         end
      end
   endtask

   task automatic launch(input vec_t v);
      @(negedge clock); #1;
      busy_cnt = 0; plot_cnt = 0; done_cnt = 0; done_at = -1; ready_viol = 0;
      push_model(v);
      req = 1'b1; req_x = v.x; req_y = v.y; req_len = v.len; req_addr = v.addr;
      fg_colour = v.fg; bg_colour = v.bg;
      @(posedge clock); #1;
      req = 1'b0;
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int cyc;
      bit finished;
      launch(v);
      cyc = 0;
      finished = 0;
      while (cyc < 2000 && !finished) begin
         @(negedge clock); #1;
         cyc++;
         if (v.poke != 0 && cyc == 100) begin
            req = 1'b1; req_x = 8'd0; req_y = 7'd0; req_len = 6'd1; req_addr = 8'd0;
            fg_colour = 3'd1; bg_colour = 3'd2;
         end
         if (cyc == 120) req = 1'b0;
         if (!busy) finished = 1;
      end
      chk({tag, "_timeout"}, int'(finished), 1);
      chk({tag, "_busy_cycles"}, busy_cnt, v.exp_busy);
      chk({tag, "_plots"}, plot_cnt, v.exp_plots);
      chk({tag, "_done_count"}, done_cnt, 1);
      chk({tag, "_done_cycle"}, done_at, v.exp_busy);
      chk({tag, "_queue_left"}, exp_q.size(), 0);
      chk({tag, "_ready_while_busy"}, ready_viol, 0);
      chk({tag, "_ready_after"}, int'(req_ready), 1);
      exp_q.delete();
   endtask

   vec_t vecs [7];

   initial begin
      vec_t rv;
      int cyc;
      for (int i = 0; i < 256; i++) tmem[i] = 7'((i * 5 + 32) % 128);
      for (int i = 0; i < 1024; i++) font[i] = 8'((i * 37) ^ (i >> 2));
      tmem[0] = 7'h41;
      for (int r = 0; r < 8; r++) font[8'h41 * 8 + r] = 8'hF0;

      //           x    y    len addr fg bg poke busy plots
      vecs[0] = '{8'd0,   7'd0,   6'd1, 8'd0,   3'd7, 3'd0, 0, 83,  64};
      vecs[1] = '{8'd10,  7'd20,  6'd3, 8'd5,   3'd3, 3'd4, 0, 247, 192};
      vecs[2] = '{8'd50,  7'd50,  6'd0, 8'd9,   3'd7, 3'd1, 0, 1,   0};
      vecs[3] = '{8'd156, 7'd0,   6'd1, 8'd0,   3'd7, 3'd0, 0, 83,  32};
      vecs[4] = '{8'd0,   7'd116, 6'd1, 8'd0,   3'd5, 3'd2, 0, 83,  32};
      vecs[5] = '{8'd150, 7'd110, 6'd2, 8'd254, 3'd6, 3'd1, 0, 165, 80};
      vecs[6] = '{8'd40,  7'd30,  6'd2, 8'd9,   3'd2, 3'd5, 1, 165, 128};

      resetn = 1'b0; req = 1'b0; req_x = '0; req_y = '0; req_len = '0; req_addr = '0;
      fg_colour = '0; bg_colour = '0;
      busy_cnt = 0; plot_cnt = 0; done_cnt = 0; done_at = -1; ready_viol = 0;
      repeat (3) @(posedge clock);
      #1;
      chk("rst_plot", int'(plot), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_ready", int'(req_ready), 1);
      chk("rst_vga_x", int'(vga_x), 0);
      chk("rst_vga_y", int'(vga_y), 0);
      chk("rst_colour", int'(colour), 0);
      chk("rst_mem_addr", int'(mem_addr), 0);
      chk("rst_font_addr", int'(font_addr), 0);
      @(negedge clock);
      resetn = 1'b1;

      for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Reset while drawing the second character: no done pulse, clean restart.
      launch(vecs[1]);
      cyc = 0;
      while (cyc < 2000 && plot_cnt < 74) begin
         @(negedge clock); #1;
         cyc++;
      end
      chk("midrst_reached_char1", int'(plot_cnt >= 74), 1);
      resetn = 1'b0;
      @(posedge clock); #1;
      chk("midrst_plot", int'(plot), 0);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_done", int'(done), 0);
      chk("midrst_ready", int'(req_ready), 1);
      @(negedge clock);
      resetn = 1'b1;
      exp_q.delete();
      repeat (5) @(negedge clock);
      #1;
      chk("midrst_no_done", done_cnt, 0);
      rv = vecs[0];
      run_vec(rv, "after_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
